vjtag_dr_controller: RTL and testbench

//   Sequences the vJTAG virtual TAP on the tck side: decodes the 4-bit virtual IR and owns the DR shift chain.

---
 rtl/vjtag_dr_controller.sv | 159 +++++++++++++++
 tb/tb_vjtag_dr_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_dr_controller.sv
// Virtual-JTAG DR path controller: decodes the virtual IR, owns the DR shift chain,
// and turns completed scans into control-register writes and clear strobes for the timer core.
module vjtag_dr_controller #(
    parameter int          TIMER_W  = 32,
    parameter int          CTRL_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h5654_4D52
) (
    input  logic               tck,
    input  logic               rst_n,
    input  logic               tdi,
    output logic               tdo,
    input  logic [3:0]         ir_in,
    output logic [3:0]         ir_out,
    input  logic               virtual_state_cdr,
    input  logic               virtual_state_sdr,
    input  logic               virtual_state_e1dr,
    input  logic               virtual_state_pdr,
    input  logic               virtual_state_e2dr,
    input  logic               virtual_state_udr,
    input  logic               virtual_state_cir,
    input  logic               virtual_state_uir,
    input  logic [TIMER_W-1:0] timer_value,
    output logic [CTRL_W-1:0]  ctrl_q,
    output logic               ctrl_stb,
    output logic               clr_stb
);

    localparam int SR_W_A = (TIMER_W > 32) ? TIMER_W : 32;
    localparam int SR_W   = (CTRL_W > SR_W_A) ? CTRL_W : SR_W_A;

    localparam logic [3:0] IR_BYPASS = 4'd0;
    localparam logic [3:0] IR_ID     = 4'd1;
    localparam logic [3:0] IR_TIMER  = 4'd2;
    localparam logic [3:0] IR_CTRL   = 4'd3;
    localparam logic [3:0] IR_STATUS = 4'd4;
    localparam logic [3:0] IR_CLEAR  = 4'd5;

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_cap;
    logic [SR_W-1:0] sr_shift;
    logic [SR_W:0]   sr_ext;
    logic [7:0]      bit_cnt;
    logic [3:0]      cur_ir;
    logic            err_len;
    logic            ctrl_valid;
    int              chain_w;

    logic            dr_hold;
    logic            udr_ctrl;
    logic            udr_ctrl_ok;
    logic            udr_ctrl_bad;
    logic            uir_clear;

    // Capture selects on the incoming IR; STATUS reports the IR of the scan before this one,
    // which is still held in cur_ir at this point.
    always_comb begin
        sr_cap = '0;
        case (ir_in)
            IR_ID:     sr_cap = SR_W'(ID_VALUE);
            IR_TIMER:  sr_cap = SR_W'(timer_value);
            IR_CTRL:   sr_cap = SR_W'(ctrl_q);
            IR_STATUS: sr_cap = SR_W'({cur_ir, 2'b00, ctrl_valid, err_len});
            default:   sr_cap = '0;
        endcase
    end

    always_comb begin
        chain_w = 1;
        case (cur_ir)
            IR_BYPASS: chain_w = 1;
            IR_ID:     chain_w = 32;
            IR_TIMER:  chain_w = TIMER_W;
            IR_CTRL:   chain_w = CTRL_W;
            IR_STATUS: chain_w = 8;
            default:   chain_w = 1;
        endcase
    end

    // tdi enters at the top of the active chain; bits above the chain are left untouched.
    assign sr_ext = {1'b0, sr};

    always_comb begin
        sr_shift = sr;
        for (int i = 0; i < SR_W; i++) begin
            if (i == chain_w - 1) begin
                sr_shift[i] = tdi;
            end else if (i < chain_w - 1) begin
                sr_shift[i] = sr_ext[i+1];
            end
        end
    end

    assign dr_hold      = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;
    assign udr_ctrl     = virtual_state_udr && !virtual_state_cdr && !virtual_state_sdr
                          && (cur_ir == IR_CTRL);
    assign udr_ctrl_ok  = udr_ctrl && (bit_cnt == 8'(CTRL_W));
    assign udr_ctrl_bad = udr_ctrl && (bit_cnt != 8'(CTRL_W));
    assign uir_clear    = virtual_state_uir && (ir_in == IR_CLEAR);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            cur_ir  <= IR_BYPASS;
        end else if (virtual_state_cdr) begin
            sr      <= sr_cap;
            bit_cnt <= '0;
            cur_ir  <= ir_in;
        end else if (virtual_state_sdr) begin
            sr <= sr_shift;
            if (bit_cnt != 8'hFF) begin
                bit_cnt <= bit_cnt + 8'd1;
            end
        end else if (dr_hold) begin
            sr      <= sr;
            bit_cnt <= bit_cnt;
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            ctrl_stb   <= 1'b0;
        end else begin
            ctrl_stb <= udr_ctrl_ok;
            if (udr_ctrl_ok) begin
                ctrl_q     <= sr[CTRL_W-1:0];
                ctrl_valid <= 1'b1;
            end
        end
    end

    // A clear on the same edge as a short CTRL update wins, so the sticky flag ends low.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
            clr_stb <= 1'b0;
        end else begin
            clr_stb <= uir_clear;
            if (uir_clear) begin
                err_len <= 1'b0;
            end else if (udr_ctrl_bad) begin
                err_len <= 1'b1;
            end
        end
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ir_out <= '0;
        end else if (virtual_state_cir) begin
            ir_out <= {2'b00, ctrl_valid, err_len};
        end
    end

    assign tdo = sr[0];

endmodule

// File: tb/tb_vjtag_dr_controller.sv
// Bench for vjtag_dr_controller: directed scans plus randomized scans checked against
// a chain-as-FIFO reference model of the DR path.
module tb_vjtag_dr_controller;

    localparam int          TIMER_W = 32;
    localparam int          CTRL_W  = 8;
    localparam logic [31:0] ID_VAL  = 32'h5654_4D52;

    logic               tck = 1'b0;
    logic               rst_n = 1'b0;
    logic               tdi = 1'b0;
    logic               tdo;
    logic [3:0]         ir_in = '0;
    logic [3:0]         ir_out;
    logic               cdr = 1'b0, sdr = 1'b0, e1dr = 1'b0, pdr = 1'b0, e2dr = 1'b0;
    logic               udr = 1'b0, cir = 1'b0, uir = 1'b0;
    logic [TIMER_W-1:0] timer_value = '0;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               ctrl_stb;
    logic               clr_stb;

    always #5 tck = ~tck;

    vjtag_dr_controller #(.TIMER_W(TIMER_W), .CTRL_W(CTRL_W), .ID_VALUE(ID_VAL)) dut (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir), .timer_value(timer_value),
        .ctrl_q(ctrl_q), .ctrl_stb(ctrl_stb), .clr_stb(clr_stb)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [CTRL_W-1:0] m_ctrl = '0;
    logic              m_valid = 1'b0;
    logic              m_err = 1'b0;
    logic [3:0]        m_prev_ir = '0;
    int                exp_ctrl_stb = 0;
    int                exp_clr_stb = 0;

    int   seen_ctrl_stb = 0;
    int   seen_clr_stb = 0;
    int   dbl = 0;
    logic last_c = 1'b0;
    logic last_k = 1'b0;

    always @(negedge tck) begin
        if (ctrl_stb) begin
            seen_ctrl_stb++;
            if (last_c) dbl++;
        end
        if (clr_stb) begin
            seen_clr_stb++;
            if (last_k) dbl++;
        end
        last_c = ctrl_stb;
        last_k = clr_stb;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mw(input logic [3:0] ir);
        case (ir)
            4'd1:    return 32;
            4'd2:    return TIMER_W;
            4'd3:    return CTRL_W;
            4'd4:    return 8;
            default: return 1;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge tck);
    endtask

    // Full DR scan: capture, n shift bits (optional pause before bit pause_at), exit, optional update.
    task automatic do_scan(input logic [3:0] ir, input int n, input logic [63:0] din,
                           input bit udr_en, input int pause_at, input string tag);
        logic [63:0] cap;
        logic [63:0] exp;
        logic [63:0] got;
        int          w;
        w = mw(ir);
        case (ir)
            4'd1:    cap = 64'(ID_VAL);
            4'd2:    cap = 64'(timer_value);
            4'd3:    cap = 64'(m_ctrl);
            4'd4:    cap = {56'd0, m_prev_ir, 2'b00, m_valid, m_err};
            default: cap = '0;
        endcase
        exp = '0;
        got = '0;
        for (int i = 0; i < n; i++) exp[i] = (i < w) ? cap[i] : din[i-w];

        ir_in = ir;
        cdr   = 1'b1;
        @(negedge tck);
        cdr         = 1'b0;
        timer_value = TIMER_W'($urandom);
        ir_in       = 4'($urandom_range(0, 15));
        for (int i = 0; i < n; i++) begin
            if (i == pause_at && i > 0) begin
                sdr  = 1'b0;
                e1dr = 1'b1; @(negedge tck); e1dr = 1'b0;
                pdr  = 1'b1; idle(10);       pdr  = 1'b0;
                e2dr = 1'b1; @(negedge tck); e2dr = 1'b0;
            end
            sdr    = 1'b1;
            tdi    = din[i];
            got[i] = tdo;
            @(negedge tck);
        end
        sdr  = 1'b0;
        e1dr = 1'b1; @(negedge tck); e1dr = 1'b0;
        if (udr_en) begin
            udr = 1'b1; @(negedge tck); udr = 1'b0;
        end
        idle(1);

        m_prev_ir = ir;
        if (udr_en && ir == 4'd3) begin
            if (n == CTRL_W) begin
                m_ctrl  = din[CTRL_W-1:0];
                m_valid = 1'b1;
                exp_ctrl_stb++;
            end else begin
                m_err = 1'b1;
            end
        end
        chk({tag, "_tdo"},  got, exp);
        chk({tag, "_ctrl"}, 64'(ctrl_q), 64'(m_ctrl));
        chk({tag, "_stb"},  64'(seen_ctrl_stb), 64'(exp_ctrl_stb));
    endtask

    task automatic do_uir(input logic [3:0] code);
        ir_in = code;
        uir   = 1'b1; @(negedge tck); uir = 1'b0;
        idle(1);
        if (code == 4'd5) begin
            m_err = 1'b0;
            exp_clr_stb++;
        end
        chk("clr_stb", 64'(seen_clr_stb), 64'(exp_clr_stb));
    endtask

    task automatic do_cir();
        cir = 1'b1; @(negedge tck); cir = 1'b0;
        chk("ir_out", 64'(ir_out), {60'd0, 2'b00, m_valid, m_err});
    endtask

    initial begin
        logic [3:0]  ir;
        int          n;
        int          op;
        logic [63:0] din;

        idle(3);
        chk("reset_outs", 64'({tdo, ir_out, ctrl_q, ctrl_stb, clr_stb}), 64'd0);
        rst_n = 1'b1;
        idle(2);

        timer_value = 32'h1234_5678;
        do_scan(4'd1, 32, {$urandom, $urandom}, 1'b1, -1, "id");
        timer_value = 32'hDEAD_BEEF;
        do_scan(4'd2, 32, {$urandom, $urandom}, 1'b0, -1, "timer");
        do_scan(4'd3, 8, 64'hA5, 1'b1, -1, "ctrl_wr");
        do_scan(4'd3, 8, {$urandom, $urandom}, 1'b0, -1, "ctrl_rd");
        do_scan(4'd3, 7, 64'h5A, 1'b1, -1, "ctrl_short");
        cir = 1'b1; @(negedge tck); cir = 1'b0;
        chk("ir_out_err", 64'(ir_out), 64'h3);
        do_uir(4'd5);
        do_scan(4'd4, 8, 64'h0, 1'b0, -1, "status");
        do_scan(4'd3, 8, 64'h3C, 1'b1, 4, "pause");
        do_scan(4'd1, 40, {$urandom, $urandom}, 1'b0, -1, "overshift");

        // reset in the middle of a CTRL shift must abort without an update
        ir_in = 4'd3; cdr = 1'b1; @(negedge tck); cdr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sdr = 1'b1; tdi = 1'b1; @(negedge tck);
        end
        sdr   = 1'b0;
        rst_n = 1'b0;
        @(negedge tck);
        chk("rst_mid_outs", 64'({tdo, ir_out, ctrl_q, ctrl_stb, clr_stb}), 64'd0);
        rst_n = 1'b1;
        m_ctrl = '0; m_valid = 1'b0; m_err = 1'b0; m_prev_ir = '0;
        udr = 1'b1; @(negedge tck); udr = 1'b0;
        idle(1);
        chk("rst_mid_stb",  64'(seen_ctrl_stb), 64'(exp_ctrl_stb));
        chk("rst_mid_ctrl", 64'(ctrl_q), 64'd0);
        do_cir();

        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                do_uir(($urandom_range(0, 1) == 1) ? 4'd5 : 4'($urandom_range(0, 15)));
            end else if (op == 1) begin
                do_cir();
            end else begin
                ir = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
                if (ir == 4'd3 && $urandom_range(0, 1) == 1) n = CTRL_W;
                else n = $urandom_range(1, mw(ir) + 8);
                din = {$urandom, $urandom};
                timer_value = TIMER_W'($urandom);
                do_scan(ir, n, din, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : -1, "rnd");
            end
        end

        chk("no_double_strobe", 64'(dbl), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
